// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32I writeback stage.
// Load funct3 encodings, default widths, load-buffer entry layout and output source select.
package wb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_LOAD = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_load_buffer.sv
// Small synchronous FIFO holding aligned load results waiting for the register-file port.
// Exposes per-slot valid/rd so the parent can build the pending-write mask.
module wb_load_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 push,
    input  wb_entry_t                            push_entry,
    input  logic                                 pop,
    output wb_entry_t                            head,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH):0]               count,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][DEF_ADDR_WIDTH-1:0] entry_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [PW-1:0]     offset_s;

    // Entry storage; stale slots are masked by the occupancy count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        offset_s    = PW'(0);
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_s       = PW'(i) - rd_ptr_r;
            entry_valid[i] = ({1'b0, offset_s} < count_r);
            entry_rd[i]    = mem_r[i].rd;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results against aligned load data for the register-file
// write port, buffering loads that collide with ALU writes and publishing a pending-write mask.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [ADDR_WIDTH-1:0]        load_rd,
    input  logic [DATA_WIDTH-1:0]        load_data,
    input  logic [1:0]                   load_addr_low,
    input  logic [2:0]                   load_funct3,
    output logic                         write_enable,
    output logic [ADDR_WIDTH-1:0]        rd,
    output logic [DATA_WIDTH-1:0]        result,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending_mask,
    output logic                         busy
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [DATA_WIDTH-1:0]                     shifted_s;
    logic [DATA_WIDTH-1:0]                     aligned_s;
    wb_src_e                                   src_s;
    logic                                      push_s;
    logic                                      pop_s;
    logic                                      load_acc_s;
    logic                                      load_ready_s;
    logic                                      full_s;
    logic                                      empty_s;
    logic [CW-1:0]                             count_s;
    wb_entry_t                                 head_s;
    wb_entry_t                                 push_entry_s;
    logic [BUF_DEPTH-1:0]                      entry_valid_s;
    logic [BUF_DEPTH-1:0][DEF_ADDR_WIDTH-1:0]  entry_rd_s;
    logic [(1<<ADDR_WIDTH)-1:0]                mask_s;

    logic                                      we_r;
    logic [ADDR_WIDTH-1:0]                     rd_r;
    logic [DATA_WIDTH-1:0]                     result_r;
    logic                                      out_is_load_r;

    // Byte-lane alignment and sign/zero extension of the raw load word.
    always_comb begin
        shifted_s = load_data >> {load_addr_low, 3'b000};
        case (load_funct3)
            F3_LB:   aligned_s = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
            F3_LH:   aligned_s = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_LBU:  aligned_s = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
            F3_LHU:  aligned_s = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
            F3_LW:   aligned_s = shifted_s;
            default: aligned_s = shifted_s;
        endcase
    end

    // Output-source priority: a full buffer always drains so ALU traffic cannot starve loads.
    always_comb begin
        src_s = SRC_NONE;
        pop_s = 1'b0;
        if (full_s) begin
            src_s = SRC_BUF;
            pop_s = 1'b1;
        end else if (alu_valid) begin
            src_s = SRC_ALU;
        end else if (!empty_s) begin
            src_s = SRC_BUF;
            pop_s = 1'b1;
        end else begin
            src_s = SRC_NONE;
        end
        load_ready_s = !reset && ((count_s < CW'(BUF_DEPTH)) || (full_s && pop_s));
        load_acc_s   = load_valid && load_ready_s;
        if (src_s == SRC_NONE && load_acc_s) begin
            src_s = SRC_LOAD;
        end else begin
            src_s = src_s;
        end
        push_s = load_acc_s && (src_s != SRC_LOAD);
    end

    assign push_entry_s = '{rd: load_rd, data: aligned_s};

    wb_load_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_load_buffer (
        .clock       (clock),
        .reset       (reset),
        .push        (push_s),
        .push_entry  (push_entry_s),
        .pop         (pop_s),
        .head        (head_s),
        .full        (full_s),
        .empty       (empty_s),
        .count       (count_s),
        .entry_valid (entry_valid_s),
        .entry_rd    (entry_rd_s)
    );

    // Register-file write port; rd=0 writes travel with the strobe suppressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_r          <= 1'b0;
            rd_r          <= '0;
            result_r      <= '0;
            out_is_load_r <= 1'b0;
        end else begin
            case (src_s)
                SRC_ALU: begin
                    we_r          <= (alu_rd != '0);
                    rd_r          <= alu_rd;
                    result_r      <= alu_result;
                    out_is_load_r <= 1'b0;
                end
                SRC_BUF: begin
                    we_r          <= (head_s.rd != '0);
                    rd_r          <= head_s.rd;
                    result_r      <= head_s.data;
                    out_is_load_r <= 1'b1;
                end
                SRC_LOAD: begin
                    we_r          <= (load_rd != '0);
                    rd_r          <= load_rd;
                    result_r      <= aligned_s;
                    out_is_load_r <= 1'b1;
                end
                default: begin
                    we_r          <= 1'b0;
                    rd_r          <= rd_r;
                    result_r      <= result_r;
                    out_is_load_r <= 1'b0;
                end
            endcase
        end
    end

    // Pending-write mask over buffered loads plus a load sitting in the output register.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            mask_s[entry_rd_s[i]] = mask_s[entry_rd_s[i]] | entry_valid_s[i];
        end
        mask_s[rd_r] = mask_s[rd_r] | out_is_load_r;
        mask_s[0]    = 1'b0;
    end

    assign alu_ready    = !reset && !full_s;
    assign load_ready   = load_ready_s;
    assign write_enable = we_r;
    assign rd           = rd_r;
    assign result       = result_r;
    assign pending_mask = mask_s;
    assign busy         = !empty_s || we_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: inputs change and outputs are checked
// on the falling edge, so every check sees state registered at the preceding rising edge.
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic [1:0]  load_addr_low;
    logic [2:0]  load_funct3;
    logic        write_enable;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] pending_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    writeback_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .BUF_DEPTH  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_result    (alu_result),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_rd       (load_rd),
        .load_data     (load_data),
        .load_addr_low (load_addr_low),
        .load_funct3   (load_funct3),
        .write_enable  (write_enable),
        .rd            (rd),
        .result        (result),
        .pending_mask  (pending_mask),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_valid  = v;
        alu_rd     = r;
        alu_result = d;
    endtask

    task automatic drive_load(input logic v, input logic [4:0] r, input logic [31:0] d,
                              input logic [1:0] a, input logic [2:0] f3);
        load_valid    = v;
        load_rd       = r;
        load_data     = d;
        load_addr_low = a;
        load_funct3   = f3;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] r,
                          input logic [31:0] d);
        chk({tag, "_we"}, {31'd0, write_enable}, {31'd0, we});
        chk({tag, "_rd"}, {27'd0, rd}, {27'd0, r});
        chk({tag, "_res"}, result, d);
    endtask

    initial begin
        reset = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_load(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
        step();
        step();

        // Reset state
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("idle_load_ready", {31'd0, load_ready}, 32'd1);

        // Single ALU write, one-cycle strobe
        drive_alu(1'b1, 5'd5, 32'h0000_1234);
        step();
        drive_alu(1'b0, 5'd0, 32'd0);
        chk_wr("alu5", 1'b1, 5'd5, 32'h0000_1234);
        chk("alu5_mask", pending_mask, 32'd0);
        chk("alu5_busy", {31'd0, busy}, 32'd1);
        step();
        chk("alu5_after_we", {31'd0, write_enable}, 32'd0);

        // Bypassed loads with alignment and extension
        drive_load(1'b1, 5'd3, 32'h80FF_7F01, 2'd2, 3'b000);
        step();
        chk_wr("lb", 1'b1, 5'd3, 32'hFFFF_FFFF);
        chk("lb_mask", pending_mask, 32'h0000_0008);
        drive_load(1'b1, 5'd3, 32'h80FF_7F01, 2'd2, 3'b100);
        step();
        chk("lbu_res", result, 32'h0000_00FF);
        drive_load(1'b1, 5'd3, 32'h80FF_7F01, 2'd2, 3'b001);
        step();
        chk("lh_res", result, 32'hFFFF_80FF);
        drive_load(1'b1, 5'd4, 32'h80FF_7F01, 2'd2, 3'b101);
        step();
        chk("lhu_res", result, 32'h0000_80FF);
        drive_load(1'b1, 5'd4, 32'h80FF_7F01, 2'd1, 3'b111);
        step();
        chk("f3_other_res", result, 32'h0080_FF7F);
        drive_load(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
        step();
        chk("load_idle_we", {31'd0, write_enable}, 32'd0);
        chk("load_idle_mask", pending_mask, 32'd0);
        chk("load_idle_busy", {31'd0, busy}, 32'd0);

        // ALU and load collide: ALU first, load buffered one cycle
        drive_alu(1'b1, 5'd1, 32'h0000_AAAA);
        drive_load(1'b1, 5'd2, 32'h1122_3344, 2'd0, 3'b010);
        step();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_load(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
        chk_wr("coll_alu", 1'b1, 5'd1, 32'h0000_AAAA);
        chk("coll_n1_mask", pending_mask, 32'h0000_0004);
        step();
        chk_wr("coll_load", 1'b1, 5'd2, 32'h1122_3344);
        chk("coll_n2_mask", pending_mask, 32'h0000_0004);
        step();
        chk("coll_n3_mask", pending_mask, 32'd0);
        chk("coll_n3_we", {31'd0, write_enable}, 32'd0);

        // Continuous ALU traffic with three back-to-back loads
        drive_alu(1'b1, 5'd10, 32'h0000_0100);
        drive_load(1'b1, 5'd20, 32'h0000_0014, 2'd0, 3'b010);
        step();
        chk_wr("st_a10", 1'b1, 5'd10, 32'h0000_0100);
        drive_alu(1'b1, 5'd11, 32'h0000_0101);
        drive_load(1'b1, 5'd21, 32'h0000_0015, 2'd0, 3'b010);
        step();
        chk_wr("st_a11", 1'b1, 5'd11, 32'h0000_0101);
        chk("st_full_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("st_full_mask", pending_mask, 32'h0030_0000);
        drive_alu(1'b1, 5'd12, 32'h0000_0102);
        drive_load(1'b1, 5'd22, 32'h0000_0016, 2'd0, 3'b010);
        step();
        drive_load(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
        chk_wr("st_l20", 1'b1, 5'd20, 32'h0000_0014);
        chk("st_refull_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("st_l20_mask", pending_mask, 32'h0070_0000);
        step();
        chk_wr("st_l21", 1'b1, 5'd21, 32'h0000_0015);
        chk("st_l21_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("st_l21_mask", pending_mask, 32'h0060_0000);
        step();
        chk_wr("st_a12", 1'b1, 5'd12, 32'h0000_0102);
        chk("st_a12_mask", pending_mask, 32'h0040_0000);
        drive_alu(1'b1, 5'd13, 32'h0000_0103);
        step();
        drive_alu(1'b0, 5'd0, 32'd0);
        chk_wr("st_a13", 1'b1, 5'd13, 32'h0000_0103);
        step();
        chk_wr("st_l22", 1'b1, 5'd22, 32'h0000_0016);
        chk("st_l22_mask", pending_mask, 32'h0040_0000);
        step();
        chk("st_end_mask", pending_mask, 32'd0);
        chk("st_end_busy", {31'd0, busy}, 32'd0);

        // Writes to x0
        drive_alu(1'b1, 5'd0, 32'h0000_0055);
        step();
        chk("x0_alu_we", {31'd0, write_enable}, 32'd0);
        drive_alu(1'b1, 5'd7, 32'h0000_0077);
        drive_load(1'b1, 5'd0, 32'hCAFE_F00D, 2'd0, 3'b010);
        step();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_load(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
        chk_wr("x0_a7", 1'b1, 5'd7, 32'h0000_0077);
        chk("x0_load_mask", pending_mask, 32'd0);
        chk("x0_load_busy", {31'd0, busy}, 32'd1);
        step();
        chk_wr("x0_load_drain", 1'b0, 5'd0, 32'hCAFE_F00D);
        chk("x0_drain_busy", {31'd0, busy}, 32'd0);

        // Reset with two buffered loads discards them
        drive_alu(1'b1, 5'd8, 32'h0000_0088);
        drive_load(1'b1, 5'd9, 32'h0000_0099, 2'd0, 3'b010);
        step();
        drive_load(1'b1, 5'd10, 32'h0000_00AA, 2'd0, 3'b010);
        step();
        chk("rb_full_mask", pending_mask, 32'h0000_0600);
        reset = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_load(1'b0, 5'd0, 32'd0, 2'd0, 3'd0);
        step();
        chk("rb_busy", {31'd0, busy}, 32'd0);
        chk("rb_mask", pending_mask, 32'd0);
        chk_wr("rb", 1'b0, 5'd0, 32'd0);
        chk("rb_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rb_load_ready", {31'd0, load_ready}, 32'd0);
        reset = 1'b0;
        step();
        chk("rb_post1_we", {31'd0, write_enable}, 32'd0);
        step();
        chk("rb_post2_we", {31'd0, write_enable}, 32'd0);
        chk("rb_post2_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
